dac_write_scheduler: RTL and testbench
======================================

Name: dac_write_scheduler

Overview:
Arbitrates two waveform/shape generators (channel A, channel B) onto the shared 8-bit parallel DAC bus. Generates the full CS/WR/AB/LDAC/CLR write sequence with parameterised setup, strobe and hold timing. Optionally defers LDAC so both DAC outputs update together. Sits between the per-channel generators and the DAC pins, and replaces free-running timing with request/ack-driven writes.

Parameters:
DATA_W, 8, DAC data bus width
SETUP_CYC, 2, cycles CS low with DB/AB stable before WR falls (>=1)
WR_LOW_CYC, 3, cycles WR held low (>=1)
HOLD_CYC, 2, cycles CS low and DB held after WR rises (>=1)
CLR_CYC, 4, cycles CLR held low for a clear (>=1)
SYNC_LDAC, 1, 1 = LDAC only after both channels written; 0 = LDAC after every write

Ports:
Clk  in  1  system clock, single clock domain
Rst  in  1  synchronous, active-high reset
enable  in  1  1 = grants allowed; 0 = finish current write, then hold IDLE
reqA  in  1  channel A write request; held until ackA
dataA  in  DATA_W  channel A sample; stable while reqA=1
ackA  out  1  one-cycle pulse; dataA latched
reqB / dataB / ackB  as for channel A
clrReq  in  1  one-cycle pulse requesting a DAC clear
DB  out  DATA_W  DAC data bus (registered)
CS  out  1  chip select, active low
WR  out  1  write strobe, active low
AB  out  1  channel select, 0=A 1=B
LDAC  out  1  load DAC, active low
CLR  out  1  clear, active low
PD  out  1  power-down control, constant 1 (operating)
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (Rst=1 at posedge) from any state, including mid-strobe: state IDLE; CS=1, WR=1, LDAC=1, CLR=1, AB=0, DB=0, ackA=ackB=0, busy=0; pendA, pendB and clrPend cleared; round-robin pointer prefers A.
- FSM states: IDLE, SETUP, STROBE, HOLD, LOAD, CLEAR. Counter width is $clog2 of the largest timing parameter + 1.
- IDLE, evaluated in priority order:
  - clrPend or clrReq set -> CLEAR.
  - Otherwise, if enable and any req -> grant.
  - Grant rules: one requester wins. If both request, grant the channel not granted last (round-robin).
  - At the grant edge: DB<=data, AB<=channel, ack pulses for 1 cycle, CS<=0, state -> SETUP.
- SETUP: lasts SETUP_CYC cycles, then WR<=0 and state -> STROBE.
- STROBE: lasts WR_LOW_CYC cycles, then WR<=1 and state -> HOLD.
- HOLD: lasts HOLD_CYC cycles, then CS<=1 and the written channel's pend flag is set.
  - If clrPend is set, go to IDLE. LOAD is skipped and CLEAR is serviced next.
  - Else, if SYNC_LDAC=0, or both pend flags are now set, go to LOAD.
  - Else go to IDLE.
- LOAD: LDAC=0 for exactly 1 cycle with CS=1, clear pendA and pendB, -> IDLE.
- CLEAR: CLR=0 for CLR_CYC cycles with CS=1 and WR=1; clear pendA, pendB and clrPend; -> IDLE.
- Timing example, defaults, grant at edge E:
  - CS low over E..E+6.
  - WR low over E+2..E+4.
  - CS high at E+7.
  - LDAC low at E+7 if LOAD is taken.
- Minimum 1 IDLE cycle (CS high) between consecutive writes.
- clrReq arriving outside IDLE sets clrPend. It never aborts a write in progress.
- clrReq and req at the same IDLE edge: clear wins; req is neither acked nor dropped.
- A channel written twice before the other (SYNC_LDAC=1): pend flag stays set; DB data is overwritten in the DAC input register; no LDAC.
- enable=0 mid-write: the current write and its LOAD complete; no new grant.
- DB and AB hold their last value until the next grant.

Decomposition:
- dac_pkg holds:
  - state enum
  - AB_CHAN_A / AB_CHAN_B constants
  - default timing constants (SETUP_CYC, WR_LOW_CYC, HOLD_CYC, CLR_CYC)
- One sub-module: dac_rr_arbiter. Two-way round-robin with inputs reqA, reqB, grantEn and outputs gntA, gntB; holds the last-grant pointer.

Test Plan:
- Defaults, SYNC_LDAC=0, reqA with dataA=8'hA5 -> ackA at E; DB=A5, AB=0; CS low 7 cycles; WR low E+2..E+4; LDAC low 1 cycle at E+7.
- SYNC_LDAC=1, reqA and reqB both high, dataA=8'h10, dataB=8'hF0 -> A granted first, then B at E+8 (one IDLE cycle). No LDAC after the A write; single LDAC pulse after the B write.
- Both requests held continuously for 4 writes -> grants alternate A,B,A,B; every write keeps CS high for >=1 cycle between writes.
- clrReq pulsed during STROBE of an A write -> write completes; LOAD skipped; CLR low 4 cycles starting the cycle after CS rises; pend flags cleared (a following B write gives no LDAC).
- Rst=1 during STROBE -> next cycle CS=WR=LDAC=CLR=1, DB=0, busy=0. A pending reqB is granted only after Rst deasserts.
- enable=0 with reqA held -> no ackA and busy=0; enable=1 -> ackA on the next edge.

Source files
------------

// File: rtl/dac_pkg.sv
// -----------------------------------------------------------------------------
// dac_pkg
// Shared definitions for the DAC write scheduler:
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - AB channel-select values
//   - default write timing, in clock cycles
//   - max2 helper used to size the shared phase counter
// -----------------------------------------------------------------------------
package dac_pkg;

    // FSM state encoding
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP  = 3'd1;
    localparam state_t ST_STROBE = 3'd2;
    localparam state_t ST_HOLD   = 3'd3;
    localparam state_t ST_LOAD   = 3'd4;
    localparam state_t ST_CLEAR  = 3'd5;

    // AB pin values
    localparam logic AB_CHAN_A = 1'b0;
    localparam logic AB_CHAN_B = 1'b1;

    // Default timing, in clock cycles
    localparam int DEF_SETUP_CYC  = 2;
    localparam int DEF_WR_LOW_CYC = 3;
    localparam int DEF_HOLD_CYC   = 2;
    localparam int DEF_CLR_CYC    = 4;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dac_rr_arbiter
// Two-way round-robin arbiter. Grants are combinational and only asserted
// while grantEn is high. When both channels request, the channel that was not
// granted last wins. After reset channel A is preferred.
//
// Ports:
//   Clk      in   system clock
//   Rst      in   synchronous active-high reset
//   reqA     in   channel A request
//   reqB     in   channel B request
//   grantEn  in   1 = a grant may be issued this cycle
//   gntA     out  channel A granted (combinational)
//   gntB     out  channel B granted (combinational)
// -----------------------------------------------------------------------------
module dac_rr_arbiter (
    input  logic Clk,
    input  logic Rst,
    input  logic reqA,
    input  logic reqB,
    input  logic grantEn,
    output logic gntA,
    output logic gntB
);

    // 1 = B has priority on the next contested grant (A was granted last)
    logic preferB;

    always_comb begin
        gntA = grantEn && reqA && (!reqB || !preferB);
        gntB = grantEn && reqB && (!reqA ||  preferB);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            preferB <= 1'b0;
        end else if (gntA) begin
            preferB <= 1'b1;
        end else if (gntB) begin
            preferB <= 1'b0;
        end
    end

endmodule

// File: rtl/dac_write_scheduler.sv
// -----------------------------------------------------------------------------
// dac_write_scheduler
// Arbitrates channel A / channel B sample requests onto a shared parallel DAC
// bus and generates the CS/WR/AB/LDAC/CLR write sequence with programmable
// setup, strobe and hold timing. With SYNC_LDAC=1, LDAC is pulsed only once
// both channels have been written, so both outputs update together.
//
// Ports:
//   Clk            in   system clock
//   Rst            in   synchronous active-high reset
//   enable         in   1 = new grants allowed; 0 = finish current write, idle
//   reqA / reqB    in   channel write requests, held until acknowledged
//   dataA / dataB  in   channel samples, stable while the request is high
//   ackA / ackB    out  one-cycle pulse when the sample is latched onto DB
//   clrReq         in   one-cycle pulse requesting a DAC clear
//   DB             out  DAC data bus (registered)
//   CS, WR         out  chip select / write strobe, active low
//   AB             out  channel select, 0 = A, 1 = B
//   LDAC, CLR      out  load / clear, active low
//   PD             out  power-down control, tied to 1 (operating)
//   busy           out  1 whenever the FSM is not idle
// -----------------------------------------------------------------------------
module dac_write_scheduler
    import dac_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int SETUP_CYC  = DEF_SETUP_CYC,
    parameter int WR_LOW_CYC = DEF_WR_LOW_CYC,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int CLR_CYC    = DEF_CLR_CYC,
    parameter int SYNC_LDAC  = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              enable,
    input  logic              reqA,
    input  logic [DATA_W-1:0] dataA,
    output logic              ackA,
    input  logic              reqB,
    input  logic [DATA_W-1:0] dataB,
    output logic              ackB,
    input  logic              clrReq,
    output logic [DATA_W-1:0] DB,
    output logic              CS,
    output logic              WR,
    output logic              AB,
    output logic              LDAC,
    output logic              CLR,
    output logic              PD,
    output logic              busy
);

    localparam int MAX_CYC = max2(max2(SETUP_CYC, WR_LOW_CYC), max2(HOLD_CYC, CLR_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    // Terminal counts: each timed phase runs for N cycles, counting 0..N-1
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             pendA;
    logic             pendB;
    logic             clrPend;
    logic             grantEn;
    logic             gntA;
    logic             gntB;
    logic             bothPend;

    // A pending or arriving clear blocks any grant in the same cycle, so the
    // request stays pending (not acked) until after the clear.
    assign grantEn = (state == ST_IDLE) && enable && !clrPend && !clrReq;

    // Pend flags as they will be once the write currently in HOLD completes
    assign bothPend = (pendA || (AB == AB_CHAN_A)) && (pendB || (AB == AB_CHAN_B));

    assign busy = (state != ST_IDLE);
    assign PD   = 1'b1;

    dac_rr_arbiter u_arb (
        .Clk     (Clk),
        .Rst     (Rst),
        .reqA    (reqA),
        .reqB    (reqB),
        .grantEn (grantEn),
        .gntA    (gntA),
        .gntB    (gntB)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            CS      <= 1'b1;
            WR      <= 1'b1;
            LDAC    <= 1'b1;
            CLR     <= 1'b1;
            AB      <= AB_CHAN_A;
            DB      <= '0;
            ackA    <= 1'b0;
            ackB    <= 1'b0;
            pendA   <= 1'b0;
            pendB   <= 1'b0;
            clrPend <= 1'b0;
        end else begin
            ackA <= 1'b0;
            ackB <= 1'b0;

            // A clear requested while busy is remembered and serviced from IDLE
            if (clrReq && (state != ST_IDLE)) begin
                clrPend <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (clrPend || clrReq) begin
                        state   <= ST_CLEAR;
                        cnt     <= '0;
                        CLR     <= 1'b0;
                        pendA   <= 1'b0;
                        pendB   <= 1'b0;
                        clrPend <= 1'b0;
                    end else if (gntA || gntB) begin
                        state <= ST_SETUP;
                        cnt   <= '0;
                        CS    <= 1'b0;
                        DB    <= gntA ? dataA : dataB;
                        AB    <= gntA ? AB_CHAN_A : AB_CHAN_B;
                        ackA  <= gntA;
                        ackB  <= gntB;
                    end
                end

                ST_SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        state <= ST_STROBE;
                        cnt   <= '0;
                        WR    <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_STROBE: begin
                    if (cnt == WR_LAST) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                        WR    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        cnt <= '0;
                        CS  <= 1'b1;
                        if (AB == AB_CHAN_B) begin
                            pendB <= 1'b1;
                        end else begin
                            pendA <= 1'b1;
                        end
                        // A queued clear takes precedence over the load pulse
                        if (clrPend) begin
                            state <= ST_IDLE;
                        end else if ((SYNC_LDAC == 0) || bothPend) begin
                            state <= ST_LOAD;
                            LDAC  <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                ST_LOAD: begin
                    state <= ST_IDLE;
                    LDAC  <= 1'b1;
                    pendA <= 1'b0;
                    pendB <= 1'b0;
                end

                ST_CLEAR: begin
                    if (cnt == CLR_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        CLR   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    CS    <= 1'b1;
                    WR    <= 1'b1;
                    LDAC  <= 1'b1;
                    CLR   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_write_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dac_write_scheduler
// Two instances share all inputs: dut (SYNC_LDAC=1) and dut0 (SYNC_LDAC=0).
// A vector table drives a single channel A write cycle by cycle; directed
// sequences cover arbitration, clear deferral, reset mid-strobe and enable.
// -----------------------------------------------------------------------------
module tb_dac_write_scheduler;

    logic       Clk = 1'b0;
    logic       Rst, enable, reqA, reqB, clrReq;
    logic [7:0] dataA, dataB;

    logic       ackA, ackB, CS, WR, AB, LDAC, CLR, PD, busy;
    logic [7:0] DB;
    logic       ackA0, ackB0, CS0, WR0, AB0, LDAC0, CLR0, PD0, busy0;
    logic [7:0] DB0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clk = ~Clk;

    dac_write_scheduler #(.DATA_W(8), .SYNC_LDAC(1)) dut (
        .Clk(Clk), .Rst(Rst), .enable(enable),
        .reqA(reqA), .dataA(dataA), .ackA(ackA),
        .reqB(reqB), .dataB(dataB), .ackB(ackB),
        .clrReq(clrReq), .DB(DB), .CS(CS), .WR(WR), .AB(AB),
        .LDAC(LDAC), .CLR(CLR), .PD(PD), .busy(busy)
    );

    dac_write_scheduler #(.DATA_W(8), .SYNC_LDAC(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .enable(enable),
        .reqA(reqA), .dataA(dataA), .ackA(ackA0),
        .reqB(reqB), .dataB(dataB), .ackB(ackB0),
        .clrReq(clrReq), .DB(DB0), .CS(CS0), .WR(WR0), .AB(AB0),
        .LDAC(LDAC0), .CLR(CLR0), .PD(PD0), .busy(busy0)
    );

    // Vector row: inputs, then expected {DB, AB, CS, WR, LDAC0, LDAC, CLR, ackA, ackB, busy}
    typedef struct packed {
        logic       rst;
        logic       en;
        logic       rqA;
        logic [7:0] dA;
        logic [7:0] xDB;
        logic [8:0] xF;
    } vec_t;

    // One sampled cycle of the directed sequences
    typedef struct packed {
        logic       cs;
        logic       wr;
        logic       ldac;
        logic       clr;
        logic       ackA;
        logic       ackB;
        logic       busy;
        logic       ab;
        logic       ldac0;
        logic [7:0] db;
    } smp_t;

    localparam int S_CS = 0, S_WR = 1, S_LDAC = 2, S_CLR = 3,
                   S_ACKA = 4, S_ACKB = 5, S_BUSY = 6, S_LDAC0 = 7;

    vec_t vt [0:9];
    smp_t tr [0:63];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic en, input logic rqA,
                                input logic [7:0] dA, input logic [7:0] xDB, input logic [8:0] xF);
        vec_t v;
        v.rst = rst; v.en = en; v.rqA = rqA; v.dA = dA; v.xDB = xDB; v.xF = xF;
        return v;
    endfunction

    function automatic logic sel(input smp_t s, input int sig);
        case (sig)
            S_CS:    return s.cs;
            S_WR:    return s.wr;
            S_LDAC:  return s.ldac;
            S_CLR:   return s.clr;
            S_ACKA:  return s.ackA;
            S_ACKB:  return s.ackB;
            S_BUSY:  return s.busy;
            default: return s.ldac0;
        endcase
    endfunction

    function automatic int count_lvl(input int sig, input logic lvl, input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (sel(tr[k], sig) == lvl) c++;
        return c;
    endfunction

    function automatic int first_lvl(input int sig, input logic lvl, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (sel(tr[k], sig) == lvl) return k;
        return -1;
    endfunction

    task automatic do_reset();
        Rst = 1'b1; enable = 1'b0; reqA = 1'b0; reqB = 1'b0; clrReq = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b0;
    endtask

    // Runs n cycles, recording dut outputs after each edge. Events are given as
    // cycle indices (-1 = never); drop releases a request once it is acked.
    task automatic trace(input int n, input bit drop, input int clr_at, input int rst_at,
                         input int reqB_at, input int en_at);
        for (int i = 0; i < n; i++) begin
            clrReq = (i == clr_at);
            Rst    = (i == rst_at);
            enable = (i >= en_at);
            if (i == reqB_at) reqB = 1'b1;
            @(posedge Clk); #1;
            tr[i] = {CS, WR, LDAC, CLR, ackA, ackB, busy, AB, LDAC0, DB};
            if (drop && ackA) reqA = 1'b0;
            if (drop && ackB) reqB = 1'b0;
        end
        clrReq = 1'b0;
        Rst    = 1'b0;
    endtask

    int   ord;
    int   nack;
    int   gapv;

    initial begin
        Rst = 1'b0; enable = 1'b0; reqA = 1'b0; reqB = 1'b0; clrReq = 1'b0;
        dataA = 8'h00; dataB = 8'h00;

        // Single A write, defaults; fields: AB CS WR LDAC0 LDAC CLR ackA ackB busy
        vt[0] = mk(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 9'b0_1_1_1_1_1_0_0_0);
        vt[1] = mk(1'b0, 1'b1, 1'b1, 8'hA5, 8'hA5, 9'b0_0_1_1_1_1_1_0_1);
        vt[2] = mk(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 9'b0_0_1_1_1_1_0_0_1);
        vt[3] = mk(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 9'b0_0_0_1_1_1_0_0_1);
        vt[4] = mk(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 9'b0_0_0_1_1_1_0_0_1);
        vt[5] = mk(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 9'b0_0_0_1_1_1_0_0_1);
        vt[6] = mk(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 9'b0_0_1_1_1_1_0_0_1);
        vt[7] = mk(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 9'b0_0_1_1_1_1_0_0_1);
        vt[8] = mk(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 9'b0_1_1_0_1_1_0_0_1);
        vt[9] = mk(1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 9'b0_1_1_1_1_1_0_0_0);

        for (int i = 0; i < 10; i++) begin
            Rst = vt[i].rst; enable = vt[i].en; reqA = vt[i].rqA; dataA = vt[i].dA;
            @(posedge Clk); #1;
            chk($sformatf("t1_row%0d", i),
                {15'd0, DB0, AB0, CS0, WR0, LDAC0, LDAC, CLR0, ackA0, ackB0, busy0},
                {15'd0, vt[i].xDB, vt[i].xF});
        end
        chk("pd_const", {30'd0, PD, PD0}, 32'd3);

        // Both request, SYNC_LDAC=1: A, then B one IDLE cycle later, one LDAC after B
        do_reset();
        dataA = 8'h10; dataB = 8'hF0; reqA = 1'b1; reqB = 1'b1;
        trace(20, 1'b1, -1, -1, -1, 0);
        chk("t2_ackA_first", {tr[0].ackA, tr[0].ackB, tr[0].ab, tr[0].db}, {1'b1, 1'b0, 1'b0, 8'h10});
        chk("t2_cs_high_e7", tr[7].cs, 1'b1);
        chk("t2_ackB_cycle", first_lvl(S_ACKB, 1'b1, 0, 19), 8);
        chk("t2_B_bus", {tr[8].ab, tr[8].db}, {1'b1, 8'hF0});
        chk("t2_ldac_count", count_lvl(S_LDAC, 1'b0, 0, 19), 1);
        chk("t2_ldac_cycle", first_lvl(S_LDAC, 1'b0, 0, 19), 15);

        // Both held continuously: grants alternate A,B,A,B with CS high between
        do_reset();
        reqA = 1'b1; reqB = 1'b1;
        trace(34, 1'b0, -1, -1, -1, 0);
        reqA = 1'b0; reqB = 1'b0;
        ord = 0; nack = 0; gapv = 0;
        for (int k = 0; k < 34; k++) begin
            if (tr[k].ackA || tr[k].ackB) begin
                nack++;
                ord = (ord << 1) | int'(tr[k].ackB);
                if (k > 0 && tr[k-1].cs != 1'b1) gapv++;
            end
        end
        chk("t3_ack_count", nack, 4);
        chk("t3_order_ABAB", ord, 32'b0101);
        chk("t3_cs_gap_viol", gapv, 0);

        // clrReq during STROBE of an A write; B requested meanwhile
        do_reset();
        dataA = 8'h33; dataB = 8'h44; reqA = 1'b1;
        trace(25, 1'b1, 3, -1, 5, 0);
        chk("t4_wr_low_cycles", count_lvl(S_WR, 1'b0, 0, 6), 3);
        chk("t4_cs_rise", {tr[6].cs, tr[7].cs}, 2'b01);
        chk("t4_clr_start", first_lvl(S_CLR, 1'b0, 0, 24), 8);
        chk("t4_clr_len", count_lvl(S_CLR, 1'b0, 0, 24), 4);
        chk("t4_cs_during_clr", count_lvl(S_CS, 1'b0, 8, 11), 0);
        chk("t4_load_skipped0", count_lvl(S_LDAC0, 1'b0, 0, 19), 0);
        chk("t4_ackB_cycle", first_lvl(S_ACKB, 1'b1, 0, 24), 13);
        chk("t4_no_ldac_after_B", count_lvl(S_LDAC, 1'b0, 0, 24), 0);

        // Reset asserted mid-strobe with B still requesting
        do_reset();
        dataA = 8'h5A; dataB = 8'hC3; reqA = 1'b1; reqB = 1'b1;
        trace(8, 1'b1, -1, 3, -1, 0);
        reqB = 1'b0;
        chk("t5_rst_outputs", {tr[3].cs, tr[3].wr, tr[3].ldac, tr[3].clr, tr[3].busy, tr[3].db},
            {1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00});
        chk("t5_ackB_after_rst", first_lvl(S_ACKB, 1'b1, 0, 7), 4);
        chk("t5_B_bus", {tr[4].ab, tr[4].db}, {1'b1, 8'hC3});

        // enable low with A requesting, then raised
        do_reset();
        dataA = 8'h77; reqA = 1'b1;
        trace(7, 1'b1, -1, -1, -1, 5);
        reqA = 1'b0;
        chk("t6_no_ack_disabled", count_lvl(S_ACKA, 1'b1, 0, 4), 0);
        chk("t6_idle_disabled", count_lvl(S_BUSY, 1'b1, 0, 4), 0);
        chk("t6_ack_on_enable", {tr[5].ackA, tr[5].db}, {1'b1, 8'h77});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
